// File: rtl/if_defs.sv
// Shared definitions for the instruction-fetch stage: bus widths, field offsets,
// the default reset PC and the packed bus layouts exchanged with ID.
package if_defs;

    localparam int IF_ID_BUS_W = 65;
    localparam int ID_IF_BUS_W = 34;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    localparam int IF_ID_ADEF_BIT = 64;
    localparam int IF_ID_PC_LSB   = 32;
    localparam int IF_ID_INST_LSB = 0;

    localparam int ID_IF_BR_TAKEN_BIT  = 33;
    localparam int ID_IF_BR_TARGET_LSB = 1;
    localparam int ID_IF_BR_STALL_BIT  = 0;

    typedef struct packed {
        logic        adef;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic        br_taken;
        logic [31:0] br_target;
        logic        br_stall;
    } id_if_t;

    function automatic logic [IF_ID_BUS_W-1:0] make_entry(
        input logic        adef,
        input logic [31:0] pc,
        input logic [31:0] inst
    );
        if_id_t e;
        e.adef = adef;
        e.pc   = pc;
        e.inst = inst;
        return e;
    endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// Parametrised synchronous FIFO with push/pop/clear and occupancy count.
// Head entry is visible on dout whenever count is non-zero.
module if_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             empty;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : PTR_W'(p + 1'b1);
    endfunction

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign rd_en = pop & ~empty;
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign wr_en = push & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (rd_en) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/if_fetch_queue.sv
// Multi-outstanding instruction fetch with an instruction queue ahead of ID.
// Optional same-cycle forwarding of SRAM data to ID: define IF_FETCH_BYPASS_EN.
module if_fetch_queue
    import if_defs::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   id_allowin,
    output logic                   if_id_valid,
    output logic [IF_ID_BUS_W-1:0] if_id_bus,
    input  logic [ID_IF_BUS_W-1:0] id_if_bus,
    input  logic                   flush_valid,
    input  logic [31:0]            flush_pc,
    output logic                   inst_sram_req,
    output logic                   inst_sram_wr,
    output logic [1:0]             inst_sram_size,
    output logic [3:0]             inst_sram_wstrb,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic                   inst_sram_addr_ok,
    input  logic                   inst_sram_data_ok,
    input  logic [31:0]            inst_sram_rdata
);

    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    id_if_t                 id_if;
    logic                   redirect;
    logic [31:0]            target;
    logic                   misaligned;
    logic                   has_credit;
    logic                   accept;
    logic                   discarding;
    logic                   resp_live;
    logic                   adef_push;
    logic                   bypass;
    logic                   bypass_take;

    logic [31:0]            fetch_pc_reg,     fetch_pc_next;
    logic [OW-1:0]          outstanding_reg,  outstanding_next;
    logic [OW-1:0]          discard_cnt_reg,  discard_cnt_next;
    logic                   adef_pending_reg, adef_pending_next;

    logic [31:0]            pc_head;
    logic [OW-1:0]          pc_count_unused;
    logic                   inst_push;
    logic                   inst_pop;
    logic                   inst_empty;
    logic [IF_ID_BUS_W-1:0] inst_din;
    logic [IF_ID_BUS_W-1:0] inst_head;
    logic [FW-1:0]          inst_count;
    logic [IF_ID_BUS_W-1:0] resp_entry;
    logic [IF_ID_BUS_W-1:0] adef_entry;

    assign id_if      = id_if_t'(id_if_bus);
    assign redirect   = flush_valid | id_if.br_taken;
    assign target     = flush_valid ? flush_pc : id_if.br_target;
    assign misaligned = (fetch_pc_reg[1:0] != 2'b00);

    // Each accepted request owns a queue slot, so a response always has room.
    assign has_credit = (32'(outstanding_reg) < 32'(MAX_OUTSTANDING))
                      & (32'(outstanding_reg) + 32'(inst_count) < 32'(FIFO_DEPTH));

    assign inst_sram_req   = ~redirect & ~id_if.br_stall & ~misaligned
                           & ~adef_pending_reg & has_credit;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_addr  = fetch_pc_reg;
    assign inst_sram_wdata = 32'h0;

    assign accept     = inst_sram_req & inst_sram_addr_ok;
    assign discarding = (discard_cnt_reg != '0);
    assign resp_live  = inst_sram_data_ok & ~discarding;

    assign adef_push  = ~redirect & misaligned & ~adef_pending_reg
                      & (outstanding_reg == '0)
                      & (32'(inst_count) < 32'(FIFO_DEPTH));

    assign resp_entry = make_entry(1'b0, pc_head, inst_sram_rdata);
    assign adef_entry = make_entry(1'b1, fetch_pc_reg, 32'h0);
    assign inst_empty = (inst_count == '0);

`ifdef IF_FETCH_BYPASS_EN
    assign bypass      = resp_live & inst_empty & ~redirect;
    assign bypass_take = bypass & id_allowin;
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign inst_push   = (resp_live & ~bypass_take) | adef_push;
    assign inst_din    = adef_push ? adef_entry : resp_entry;
    assign if_id_valid = ~redirect & (~inst_empty | bypass);
    assign if_id_bus   = bypass ? resp_entry : inst_head;
    assign inst_pop    = if_id_valid & id_allowin & ~inst_empty;

    always_comb begin
        fetch_pc_next     = fetch_pc_reg;
        adef_pending_next = adef_pending_reg;
        outstanding_next  = outstanding_reg + OW'(accept) - OW'(inst_sram_data_ok);
        discard_cnt_next  = discard_cnt_reg - OW'(inst_sram_data_ok & discarding);
        if (redirect) begin
            // Every response still owed after this cycle belongs to the old path,
            // including ones already marked for discard.
            discard_cnt_next  = outstanding_reg - OW'(inst_sram_data_ok);
            fetch_pc_next     = target;
            adef_pending_next = 1'b0;
        end else begin
            if (accept) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (adef_push) begin
                adef_pending_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_reg     <= RESET_PC;
            outstanding_reg  <= '0;
            discard_cnt_reg  <= '0;
            adef_pending_reg <= 1'b0;
        end else begin
            fetch_pc_reg     <= fetch_pc_next;
            outstanding_reg  <= outstanding_next;
            discard_cnt_reg  <= discard_cnt_next;
            adef_pending_reg <= adef_pending_next;
        end
    end

    if_sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_queue (
        .clk   (clk),
        .rst_n (resetn),
        .clear (redirect),
        .push  (accept),
        .din   (fetch_pc_reg),
        .pop   (resp_live),
        .dout  (pc_head),
        .count (pc_count_unused)
    );

    if_sync_fifo #(
        .WIDTH (IF_ID_BUS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_queue (
        .clk   (clk),
        .rst_n (resetn),
        .clear (redirect),
        .push  (inst_push),
        .din   (inst_din),
        .pop   (inst_pop),
        .dout  (inst_head),
        .count (inst_count)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised and directed bench for if_fetch_queue against a queue-based model of
// the fetch stream (in-flight requests tagged live/stale, instruction list toward ID).
module tb_if_fetch_queue;
    import if_defs::*;

    localparam int          MAXO   = 2;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h1c00_0000;
`ifdef IF_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_allowin;
    logic        if_id_valid;
    logic [64:0] if_id_bus;
    logic [33:0] id_if_bus;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .MAX_OUTSTANDING (MAXO),
        .FIFO_DEPTH      (DEPTH),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .id_allowin        (id_allowin),
        .if_id_valid       (if_id_valid),
        .if_id_bus         (if_id_bus),
        .id_if_bus         (id_if_bus),
        .flush_valid       (flush_valid),
        .flush_pc          (flush_pc),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        live;
    } fl_t;

    fl_t         infl[$];
    logic [64:0] mq[$];
    logic [64:0] cap[$];
    logic [31:0] m_pc;
    bit          m_adefp;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int cyc = 0;
    int first_dok = -1;
    int first_val = -1;

    bit          p_aok, p_dok, p_allow, p_stall, p_br, p_flush;
    logic [31:0] p_btgt, p_fpc;

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_0f0f;
    endfunction

    function automatic logic [64:0] cap_entry(input int i);
        if (i < cap.size()) return cap[i];
        return 65'bx;
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic plan(input bit aok, input bit dok, input bit allow, input bit stall,
                        input bit br, input logic [31:0] btgt, input bit fl,
                        input logic [31:0] fpc);
        p_aok = aok; p_dok = dok; p_allow = allow; p_stall = stall;
        p_br = br; p_btgt = btgt; p_flush = fl; p_fpc = fpc;
    endtask

    // One cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step();
        logic        redir, mis, exp_req, byp, exp_val, accept, take, adef_push, dok;
        logic [31:0] tgt;
        logic [64:0] exp_bus;
        fl_t         f;
        @(negedge clk);
        dok = p_dok && (infl.size() > 0);
        inst_sram_addr_ok = p_aok;
        inst_sram_data_ok = dok;
        inst_sram_rdata   = dok ? sram_word(infl[0].addr) : $urandom;
        id_allowin  = p_allow;
        id_if_bus   = {p_br, p_btgt, p_stall};
        flush_valid = p_flush;
        flush_pc    = p_fpc;
        #1;
        redir   = p_flush | p_br;
        tgt     = p_flush ? p_fpc : p_btgt;
        mis     = (m_pc[1:0] != 2'b00);
        exp_req = !redir && !p_stall && !mis && !m_adefp && (infl.size() < MAXO)
                  && (infl.size() + mq.size() < DEPTH);
        byp     = BYP && !redir && dok && (mq.size() == 0) && infl[0].live;
        exp_val = !redir && ((mq.size() > 0) || byp);
        exp_bus = (mq.size() > 0) ? mq[0] : {1'b0, infl[0].addr, sram_word(infl[0].addr)};

        chk("sram_req", inst_sram_req, exp_req);
        chk("sram_addr", inst_sram_addr, m_pc);
        chk("if_id_valid", if_id_valid, exp_val);
        if (exp_val) chk("if_id_bus", if_id_bus, exp_bus);

        if (if_id_valid && id_allowin) cap.push_back(if_id_bus);
        if (inst_sram_req && inst_sram_addr_ok) acc_cnt++;
        if (dok && first_dok < 0) first_dok = cyc;
        if (if_id_valid && first_val < 0) first_val = cyc;
        cyc++;

        accept    = exp_req && p_aok;
        take      = exp_val && p_allow;
        adef_push = !redir && mis && !m_adefp && (infl.size() == 0) && (mq.size() < DEPTH);
        if (redir) begin
            if (dok) void'(infl.pop_front());
            for (int i = 0; i < infl.size(); i++) begin
                f = infl[i];
                f.live = 1'b0;
                infl[i] = f;
            end
            mq.delete();
            m_pc = tgt;
            m_adefp = 1'b0;
        end else begin
            if (take && mq.size() > 0) void'(mq.pop_front());
            if (dok) begin
                f = infl.pop_front();
                if (f.live && !(byp && take)) mq.push_back({1'b0, f.addr, sram_word(f.addr)});
            end
            if (accept) begin
                f.addr = m_pc;
                f.live = 1'b1;
                infl.push_back(f);
                m_pc = m_pc + 32'd4;
            end
            if (adef_push) begin
                mq.push_back({1'b1, m_pc, 32'h0});
                m_adefp = 1'b1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [64:0] e;
        resetn = 1'b0;
        id_allowin = 1'b0;
        id_if_bus = '0;
        flush_valid = 1'b0;
        flush_pc = '0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata = '0;
        m_pc = RST_PC;
        m_adefp = 1'b0;
        plan(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", if_id_valid, 1'b0);
        chk("rst_addr", inst_sram_addr, RST_PC);
        chk("tie_wr", inst_sram_wr, 1'b0);
        chk("tie_size", inst_sram_size, 2'b10);
        resetn = 1'b1;

        // Back-to-back fetch from reset, ID always ready.
        cyc = 0;
        cap.delete();
        plan(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        run(8);
        e = cap_entry(0);
        chk("A_first_pc", e[63:32], 32'h1c00_0000);
        e = cap_entry(1);
        chk("A_second_pc", e[63:32], 32'h1c00_0004);
        chk("A_dok_cycle", 65'(first_dok), 65'd1);
        chk("A_latency", 65'(first_val - first_dok), BYP ? 65'd0 : 65'd1);

        // Credit limit with ID stalled.
        plan(0, 1, 1, 0, 0, 32'h0, 1, 32'h1c00_0200);
        run(1);
        plan(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        run(4);
        acc_cnt = 0;
        plan(1, 1, 0, 0, 0, 32'h0, 0, 32'h0);
        run(12);
        chk("B_fill_accepts", 65'(acc_cnt), 65'd4);
        chk("B_req_blocked", inst_sram_req, 1'b0);
        acc_cnt = 0;
        plan(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        run(1);
        plan(1, 1, 0, 0, 0, 32'h0, 0, 32'h0);
        run(5);
        chk("B_refill_accepts", 65'(acc_cnt), 65'd1);

        // Branch with two requests in flight: both responses dropped.
        plan(0, 1, 1, 0, 0, 32'h0, 1, 32'h1c00_0300);
        run(1);
        plan(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        run(4);
        plan(1, 0, 1, 0, 0, 32'h0, 0, 32'h0);
        run(3);
        plan(0, 0, 1, 0, 1, 32'h1c00_0100, 0, 32'h0);
        cap.delete();
        run(1);
        plan(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        run(8);
        e = cap_entry(0);
        chk("C_pc_after_br", e[63:32], 32'h1c00_0100);

        // Flush beats a simultaneous branch.
        cap.delete();
        plan(1, 1, 1, 0, 1, 32'h1c00_0040, 1, 32'h1c00_8000);
        run(1);
        plan(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        run(8);
        e = cap_entry(0);
        chk("D_pc_after_flush", e[63:32], 32'h1c00_8000);

        // Misaligned target: one adef entry, no fetch afterwards.
        cap.delete();
        acc_cnt = 0;
        plan(1, 1, 1, 0, 1, 32'h1c00_0102, 0, 32'h0);
        run(1);
        plan(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        run(8);
        chk("E_accepts", 65'(acc_cnt), 65'd0);
        chk("E_entries", 65'(cap.size()), 65'd1);
        e = cap_entry(0);
        chk("E_adef", e[64], 1'b1);
        chk("E_pc", e[63:32], 32'h1c00_0102);
        chk("E_inst", e[31:0], 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            p_aok   = ($urandom % 4) != 0;
            p_dok   = ($urandom % 3) != 0;
            p_allow = ($urandom % 3) != 0;
            p_stall = ($urandom % 8) == 0;
            p_br    = ($urandom % 20) == 0;
            p_flush = ($urandom % 40) == 0;
            p_btgt  = 32'h1c00_0000 + ($urandom_range(0, 255) << 2)
                      + ((($urandom % 8) == 0) ? $urandom_range(1, 3) : 0);
            p_fpc   = 32'h1c00_8000 + ($urandom_range(0, 255) << 2)
                      + ((($urandom % 8) == 0) ? $urandom_range(1, 3) : 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
